regfile_multiport: RTL and testbench

// - Parametrised general-purpose register file for the CPU datapath: NUM_RD synchronous read ports, one write port.
// - Adds three features: write-to-read bypass, optional hard-wired zero register, and a per-register pending scoreboard.
// - Sits between decode (read addresses, scoreboard set) and writeback (write port, scoreboard clear).
// - Decode uses pend_out to stall on operands whose producer has not yet written back.

---
 rtl/regfile_multiport_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_multiport.sv | 82 ++++++++
 tb/tb_regfile_multiport.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared defaults for the multiport register file.
// Default width, depth, address size and read-port count.
package regfile_multiport_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_RD   = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits; set wins over clear on the same reg.
// Ports: clk, rst, sb_set/sb_reg, clr/clr_reg, pend_nxt (next state).
module regfile_scoreboard
  import regfile_multiport_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_reg,
  input  logic                clr,
  input  logic [ADDR_W-1:0]   clr_reg,
  output logic [NUM_REGS-1:0] pend_nxt
);

  logic [NUM_REGS-1:0] pend_q;
  logic                set_ok;

  assign set_ok = sb_set &&
    !((ZERO_R0 != 0) && (sb_reg == '0));

  // Set applied last: a newer producer stays outstanding.
  always_comb begin
    pend_nxt = pend_q;
    if (clr)
      pend_nxt[clr_reg] = 1'b0;
    if (set_ok)
      pend_nxt[sb_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= pend_nxt;
  end

endmodule

// File: rtl/regfile_multiport.sv
// Register file: NUM_RD registered read ports, one write port,
// write bypass, optional zero r0, pending scoreboard (pend_out).
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_R0  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        pend_out,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_reg
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nxt;
  logic                wr_en;

  assign wr_en = reg_write &&
    !((ZERO_R0 != 0) && (write_reg == '0));

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (sb_set),
    .sb_reg   (sb_reg),
    .clr      (wr_en),
    .clr_reg  (write_reg),
    .pend_nxt (pend_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++)
        regs[k] <= '0;
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zhit;
    logic              byp;
    logic [DATA_W-1:0] dq;
    logic              pq;

    assign ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign zhit = (ZERO_R0 != 0) && (ra == '0);
    assign byp  = wr_en && (write_reg == ra);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dq <= '0;
        pq <= 1'b0;
      end else if (zhit) begin
        dq <= '0;
        pq <= 1'b0;
      end else begin
        dq <= byp ? write_data : regs[ra];
        pq <= pend_nxt[ra];
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = dq;
    assign pend_out[i] = pq;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed checks on default and zero-r0 builds, plus a
// randomized 32x32, 3-port run against a behavioural model.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rd_addr = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        sb_set = 1'b0;
  logic [3:0]  sb_reg = '0;
  logic [31:0] rd_a, rd_z;
  logic [1:0]  pend_a, pend_z;

  logic [14:0] s_addr = '0;
  logic [95:0] s_rd;
  logic [2:0]  s_pend;
  logic        s_we = 1'b0;
  logic [4:0]  s_wa = '0;
  logic [31:0] s_wd = '0;
  logic        s_set = 1'b0;
  logic [4:0]  s_sr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.ZERO_R0(0)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr),
    .rd_data(rd_a), .pend_out(pend_a),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .sb_set(sb_set),
    .sb_reg(sb_reg)
  );

  regfile_multiport #(.ZERO_R0(1)) u_z (
    .clk(clk), .rst(rst), .rd_addr(rd_addr),
    .rd_data(rd_z), .pend_out(pend_z),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .sb_set(sb_set),
    .sb_reg(sb_reg)
  );

  regfile_multiport #(
    .DATA_W(32), .NUM_REGS(32), .ADDR_W(5),
    .NUM_RD(3), .ZERO_R0(1)
  ) u_s (
    .clk(clk), .rst(rst), .rd_addr(s_addr),
    .rd_data(s_rd), .pend_out(s_pend),
    .reg_write(s_we), .write_reg(s_wa),
    .write_data(s_wd), .sb_set(s_set),
    .sb_reg(s_sr)
  );

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [3:0] wa,
                     input logic [15:0] wd, input logic st,
                     input logic [3:0] sr, input logic [3:0] a0,
                     input logic [3:0] a1);
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    sb_set     = st;
    sb_reg     = sr;
    rd_addr    = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_mem [32];
  logic [31:0] m_pend;
  logic [31:0] m_pn;
  logic [95:0] e_rd;
  logic [2:0]  e_pd;
  logic        m_wr;
  logic [4:0]  ra;

  initial begin
    // reset state
    @(posedge clk);
    #1;
    chk("rst_rd_a", 96'(rd_a), 96'h0);
    chk("rst_pend_a", 96'(pend_a), 96'h0);
    chk("rst_rd_z", 96'(rd_z), 96'h0);
    rst = 1'b0;

    // reset mid-operation
    cyc(1, 4'd3, 16'h1234, 1, 4'd6, 4'd0, 4'd0);
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd6);
    chk("pre_rst_rd", 96'(rd_a[15:0]), 96'h1234);
    chk("pre_rst_pend", 96'(pend_a[1]), 96'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rd", 96'(rd_a), 96'h0);
    chk("mid_rst_pend", 96'(pend_a), 96'h0);
    chk("mid_rst_pend_z", 96'(pend_z), 96'h0);
    #1 rst = 1'b0;
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd6);
    chk("post_rst_r3", 96'(rd_a[15:0]), 96'h0);
    chk("post_rst_p6", 96'(pend_a[1]), 96'h0);

    // basic write then dual read
    cyc(1, 4'd5, 16'hBEEF, 0, 4'd0, 4'd0, 4'd0);
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd5, 4'd5);
    chk("basic_p0", 96'(rd_a[15:0]), 96'hBEEF);
    chk("basic_p1", 96'(rd_a[31:16]), 96'hBEEF);

    // bypass
    cyc(1, 4'd7, 16'h0001, 0, 4'd0, 4'd0, 4'd0);
    cyc(1, 4'd7, 16'hAAAA, 0, 4'd0, 4'd7, 4'd7);
    chk("byp_p0", 96'(rd_a[15:0]), 96'hAAAA);
    chk("byp_p1", 96'(rd_a[31:16]), 96'hAAAA);
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd7, 4'd0);
    chk("byp_stored", 96'(rd_a[15:0]), 96'hAAAA);

    // zero register
    cyc(1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd0, 4'd0);
    chk("r0_byp_a", 96'(rd_a[15:0]), 96'hFFFF);
    chk("r0_byp_pend_a", 96'(pend_a[0]), 96'h1);
    chk("r0_byp_z", 96'(rd_z[15:0]), 96'h0);
    chk("r0_byp_pend_z", 96'(pend_z[0]), 96'h0);
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
    chk("r0_a", 96'(rd_a[15:0]), 96'hFFFF);
    chk("r0_pend_a", 96'(pend_a[0]), 96'h1);
    chk("r0_z", 96'(rd_z[15:0]), 96'h0);
    chk("r0_pend_z", 96'(pend_z[0]), 96'h0);

    // scoreboard
    cyc(0, 4'd0, 16'h0, 1, 4'd2, 4'd2, 4'd0);
    chk("sb_set_r2", 96'(pend_a[0]), 96'h1);
    cyc(1, 4'd2, 16'h2222, 1, 4'd2, 4'd2, 4'd0);
    chk("sb_setwin", 96'(pend_a[0]), 96'h1);
    chk("sb_setwin_d", 96'(rd_a[15:0]), 96'h2222);
    cyc(1, 4'd2, 16'h3333, 1, 4'd9, 4'd2, 4'd9);
    chk("sb_clr_r2", 96'(pend_a[0]), 96'h0);
    chk("sb_clr_d", 96'(rd_a[15:0]), 96'h3333);
    chk("sb_set_r9", 96'(pend_z[1]), 96'h1);
    cyc(1, 4'd9, 16'h9999, 1, 4'd4, 4'd4, 4'd9);
    chk("sb_both_p4", 96'(pend_a[0]), 96'h1);
    chk("sb_both_p9", 96'(pend_a[1]), 96'h0);
    chk("sb_both_d9", 96'(rd_a[31:16]), 96'h9999);
    cyc(0, 4'd0, 16'h0, 0, 4'd0, 4'd4, 4'd9);
    chk("sb_hold", 96'(pend_z), 96'h1);

    // randomized sweep vs model
    for (int k = 0; k < 32; k++) m_mem[k] = '0;
    m_pend = '0;
    for (int n = 0; n < 10000; n++) begin
      s_we  = 1'($urandom_range(0, 1));
      s_set = 1'($urandom_range(0, 1));
      s_wd  = $urandom;
      if (n[0]) begin
        s_wa   = 5'($urandom_range(0, 3));
        s_sr   = 5'($urandom_range(0, 3));
        s_addr = {5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3))};
      end else begin
        s_wa   = 5'($urandom);
        s_sr   = 5'($urandom);
        s_addr = 15'($urandom);
      end
      m_wr = s_we && (s_wa != 5'd0);
      m_pn = m_pend;
      if (m_wr) m_pn[s_wa] = 1'b0;
      if (s_set && s_sr != 5'd0) m_pn[s_sr] = 1'b1;
      for (int p = 0; p < 3; p++) begin
        ra = s_addr[p*5 +: 5];
        if (ra == 5'd0) begin
          e_rd[p*32 +: 32] = '0;
          e_pd[p] = 1'b0;
        end else begin
          e_rd[p*32 +: 32] =
            (m_wr && s_wa == ra) ? s_wd : m_mem[ra];
          e_pd[p] = m_pn[ra];
        end
      end
      if (m_wr) m_mem[s_wa] = s_wd;
      m_pend = m_pn;
      @(posedge clk);
      #1;
      chk("sweep_rd", s_rd, e_rd);
      chk("sweep_pend", 96'(s_pend), 96'(e_pd));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
